vote_tally_reader: RTL and testbench
====================================

Name: vote_tally_reader

Overview:
- Reads back the per-candidate vote tallies held by the voting system's up-counters. Scans N candidate counts sequentially through a select/read interface, then reports:
  - the winner,
  - the winning count,
  - a tie flag,
  - the total number of votes.
- Sits between the bank of vote counters and the result display/output logic.
- Asserts busy so upstream logic can hold off vote increments during a scan.

Parameters:
- N_CAND, 4, number of candidates/counters scanned (2..16)
- CNT_W, 21, width of each tally counter
- SEL_W, 2, width of the candidate index; must satisfy 2**SEL_W >= N_CAND

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a scan; sampled only in IDLE
- rd_sel  out  SEL_W  index of the counter currently being read
- rd_count  in  CNT_W  tally of counter rd_sel; combinational mux of registered counters, valid in the same cycle
- busy  out  1  high from the cycle after start is accepted through the DONE cycle inclusive
- done  out  1  one-cycle pulse, results valid
- result_valid  out  1  high from done until the next accepted start or rst
- winner  out  SEL_W  index of the highest tally
- winner_count  out  CNT_W  tally of winner
- tie  out  1  another candidate equals winner_count
- total  out  CNT_W+SEL_W  sum of all N_CAND tallies

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all outputs 0; state is IDLE.
- State machine: IDLE, SCAN, DONE.
  - IDLE: if start=1, go to SCAN. Clear the accumulators (max=0, idx=0, tie=0, sum=0), set rd_sel=0, set result_valid=0.
  - SCAN: each cycle, sample rd_count for the current rd_sel (i):
    - i==0: max<=rd_count, idx<=0, tie<=0.
    - i>0 and rd_count > max: max<=rd_count, idx<=i, tie<=0.
    - i>0 and rd_count == max: tie<=1; max and idx unchanged, so the lowest index wins a tie.
    - i>0 and rd_count < max: no change.
    - Every cycle: sum <= sum + zero-extended rd_count.
    - If i==N_CAND-1, go to DONE; otherwise rd_sel<=i+1.
  - DONE: copy the accumulators to winner, winner_count, tie and total. Pulse done=1 and set result_valid=1. Return to IDLE; rd_sel returns to 0.
- Latency: start accepted at cycle T, SCAN occupies T+1..T+N_CAND, done is high at T+N_CAND+1. Next start is accepted from T+N_CAND+2.
- Comparison is unsigned at full CNT_W.
- total cannot overflow: CNT_W+SEL_W bits covers N_CAND*(2**CNT_W-1).
- All-zero tallies: winner=0, winner_count=0, tie=1.
- All counts at maximum (2**CNT_W-1): tie=1, total=N_CAND*(2**CNT_W-1), no wrap.
- start while busy (SCAN/DONE) is ignored, not queued.
- start held high continuously: a new scan begins every N_CAND+2 cycles.
- winner/winner_count/tie/total hold their last values until the next DONE; result_valid drops on an accepted start.
- rst in any state, including mid-scan: next cycle is IDLE with all outputs 0, no done pulse, partial results discarded.
- rd_count changing mid-scan is not detected; the consumer must gate vote increments with busy.

Decomposition:
- Shared package (voting system package) holds:
  - the state enum {IDLE, SCAN, DONE},
  - default CNT_W=21,
  - the candidate count constant, shared with the counter bank.
- One natural sub-module: vote_max_tracker. It holds the registered running max/idx/tie/sum, with inputs clear, sample_en, first, index and value.
- The FSM and rd_sel sequencing stay in vote_tally_reader.

Test Plan:
- Tallies {5,12,3,7}, start pulse at cycle 0 -> rd_sel 0,1,2,3 on cycles 1-4; done at cycle 5 with winner=1, winner_count=12, tie=0, total=27, result_valid=1.
- Tallies {9,4,9,1} -> winner=0, winner_count=9, tie=1, total=23.
- Tallies {0,0,0,0} -> winner=0, winner_count=0, tie=1, total=0.
- Tallies all 2**21-1 -> winner=0, tie=1, total=4*(2**21-1)=8388604.
- Tallies {1,2,3,4}, start repeated at cycles 2 and 3 during SCAN -> ignored; exactly one done at cycle 5 with winner=3, total=10.
- Tallies {5,12,3,7}, rst=1 at cycle 3 mid-scan -> at cycle 4 busy=0, done never pulses, all outputs 0. A new start then completes normally with winner=1.

Source files
------------

// File: rtl/vote_tally_reader_pkg.sv
// Shared voting-system definitions: scan FSM states and the default counter-bank geometry.
package vote_tally_reader_pkg;

    localparam int unsigned DefCntW = 21;
    localparam int unsigned NumCand = 4;
    localparam int unsigned DefSelW = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/vote_tally_reader_max.sv
// Running max/index/tie/sum accumulator fed one tally per cycle during a scan.
module vote_max_tracker
    import vote_tally_reader_pkg::*;
#(
    parameter int unsigned CntW = DefCntW,
    parameter int unsigned SelW = DefSelW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 sample_en_i,
    input  logic                 first_i,
    input  logic [SelW-1:0]      index_i,
    input  logic [CntW-1:0]      value_i,
    output logic [CntW-1:0]      max_o,
    output logic [SelW-1:0]      idx_o,
    output logic                 tie_o,
    output logic [CntW+SelW-1:0] sum_o
);

    localparam int unsigned SumW = CntW + SelW;

    logic [CntW-1:0] max_q, max_d;
    logic [SelW-1:0] idx_q, idx_d;
    logic            tie_q, tie_d;
    logic [SumW-1:0] sum_q, sum_d;

    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        tie_d = tie_q;
        sum_d = sum_q;
        if (clear_i) begin
            max_d = '0;
            idx_d = '0;
            tie_d = 1'b0;
            sum_d = '0;
        end else if (sample_en_i) begin
            sum_d = sum_q + SumW'(value_i);
            if (first_i) begin
                max_d = value_i;
                idx_d = '0;
                tie_d = 1'b0;
            end else if (value_i > max_q) begin
                max_d = value_i;
                idx_d = index_i;
                tie_d = 1'b0;
            end else if (value_i == max_q) begin
                // Keep the earlier index so the lowest candidate wins a tie.
                tie_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            max_q <= '0;
            idx_q <= '0;
            tie_q <= 1'b0;
            sum_q <= '0;
        end else begin
            max_q <= max_d;
            idx_q <= idx_d;
            tie_q <= tie_d;
            sum_q <= sum_d;
        end
    end

    assign max_o = max_q;
    assign idx_o = idx_q;
    assign tie_o = tie_q;
    assign sum_o = sum_q;

endmodule

// File: rtl/vote_tally_reader.sv
// Scans the candidate tally counters one per cycle and reports winner, count, tie and total.
module vote_tally_reader
    import vote_tally_reader_pkg::*;
#(
    parameter int unsigned NCand = NumCand,
    parameter int unsigned CntW  = DefCntW,
    parameter int unsigned SelW  = DefSelW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic [SelW-1:0]      rd_sel_o,
    input  logic [CntW-1:0]      rd_count_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 result_valid_o,
    output logic [SelW-1:0]      winner_o,
    output logic [CntW-1:0]      winner_count_o,
    output logic                 tie_o,
    output logic [CntW+SelW-1:0] total_o
);

    localparam int unsigned SumW = CntW + SelW;
    localparam logic [SelW-1:0] LastSel = SelW'(NCand - 1);

    state_e          state_q, state_d;
    logic [SelW-1:0] rd_sel_q, rd_sel_d;

    logic [SelW-1:0] winner_q, winner_d;
    logic [CntW-1:0] wcount_q, wcount_d;
    logic            tie_q, tie_d;
    logic [SumW-1:0] total_q, total_d;
    logic            rvalid_q, rvalid_d;

    logic            acc_clear;
    logic            acc_sample;
    logic            acc_first;
    logic [CntW-1:0] acc_max;
    logic [SelW-1:0] acc_idx;
    logic            acc_tie;
    logic [SumW-1:0] acc_sum;

    vote_max_tracker #(
        .CntW (CntW),
        .SelW (SelW)
    ) u_tracker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (acc_clear),
        .sample_en_i (acc_sample),
        .first_i     (acc_first),
        .index_i     (rd_sel_q),
        .value_i     (rd_count_i),
        .max_o       (acc_max),
        .idx_o       (acc_idx),
        .tie_o       (acc_tie),
        .sum_o       (acc_sum)
    );

    always_comb begin
        state_d    = state_q;
        rd_sel_d   = rd_sel_q;
        acc_clear  = 1'b0;
        acc_sample = 1'b0;
        acc_first  = 1'b0;
        winner_d   = winner_q;
        wcount_d   = wcount_q;
        tie_d      = tie_q;
        total_d    = total_q;
        rvalid_d   = rvalid_q;
        unique case (state_q)
            StIdle: begin
                rd_sel_d = '0;
                if (start_i) begin
                    state_d   = StScan;
                    acc_clear = 1'b1;
                    rvalid_d  = 1'b0;
                end
            end
            StScan: begin
                acc_sample = 1'b1;
                acc_first  = (rd_sel_q == '0);
                if (rd_sel_q == LastSel) begin
                    state_d = StDone;
                end else begin
                    rd_sel_d = rd_sel_q + 1'b1;
                end
            end
            StDone: begin
                state_d  = StIdle;
                rd_sel_d = '0;
                winner_d = acc_idx;
                wcount_d = acc_max;
                tie_d    = acc_tie;
                total_d  = acc_sum;
                rvalid_d = 1'b1;
            end
            default: begin
                state_d  = StIdle;
                rd_sel_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            rd_sel_q <= '0;
            winner_q <= '0;
            wcount_q <= '0;
            tie_q    <= 1'b0;
            total_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_sel_q <= rd_sel_d;
            winner_q <= winner_d;
            wcount_q <= wcount_d;
            tie_q    <= tie_d;
            total_q  <= total_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Results are visible during the DONE cycle straight from the accumulators, then held.
    assign busy_o         = (state_q != StIdle);
    assign done_o         = (state_q == StDone);
    assign rd_sel_o       = rd_sel_q;
    assign result_valid_o = rvalid_q | done_o;
    assign winner_o       = done_o ? acc_idx : winner_q;
    assign winner_count_o = done_o ? acc_max : wcount_q;
    assign tie_o          = done_o ? acc_tie : tie_q;
    assign total_o        = done_o ? acc_sum : total_q;

endmodule

// File: tb/tb_vote_tally_reader.sv
// Randomised bench for vote_tally_reader against a cycle-phase reference model of the scan.
module tb_vote_tally_reader;

    localparam int N    = 4;
    localparam int CW   = 21;
    localparam int SW   = 2;
    localparam int TW   = CW + SW;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] rd_sel_o;
    logic [CW-1:0] rd_count;
    logic          busy_o, done_o, result_valid_o, tie_o;
    logic [SW-1:0] winner_o;
    logic [CW-1:0] winner_count_o;
    logic [TW-1:0] total_o;

    logic [CW-1:0] tally [N];

    int n_err = 0;
    int n_checks = 0;
    int n_done = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    assign rd_count = tally[rd_sel_o];

    vote_tally_reader dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .rd_sel_o       (rd_sel_o),
        .rd_count_i     (rd_count),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .result_valid_o (result_valid_o),
        .winner_o       (winner_o),
        .winner_count_o (winner_count_o),
        .tie_o          (tie_o),
        .total_o        (total_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result of a complete scan of the current tallies.
    logic [SW-1:0] exp_w;
    logic [CW-1:0] exp_wc;
    logic          exp_tie;
    logic [TW-1:0] exp_tot;
    always_comb begin
        int cnt;
        exp_w   = '0;
        exp_wc  = tally[0];
        exp_tot = '0;
        cnt     = 0;
        for (int i = 1; i < N; i++) begin
            if (tally[i] > exp_wc) begin
                exp_wc = tally[i];
                exp_w  = SW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            exp_tot = exp_tot + TW'(tally[i]);
            if (tally[i] == exp_wc) cnt++;
        end
        exp_tie = (cnt > 1);
    end

    // Model: phase 0 idle, 1..N scanning candidate phase-1, N+1 done.
    int            m_phase = 0;
    logic          m_rv;
    logic [SW-1:0] m_win;
    logic [CW-1:0] m_wc;
    logic          m_tie;
    logic [TW-1:0] m_tot;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_rv    <= 1'b0;
            m_win   <= '0;
            m_wc    <= '0;
            m_tie   <= 1'b0;
            m_tot   <= '0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1;
                m_rv    <= 1'b0;
            end
        end else if (m_phase <= N) begin
            m_phase <= m_phase + 1;
        end else begin
            m_phase <= 0;
            m_rv    <= 1'b1;
            m_win   <= exp_w;
            m_wc    <= exp_wc;
            m_tie   <= exp_tie;
            m_tot   <= exp_tot;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            automatic logic ed = (m_phase == N + 1);
            check("busy", 32'(busy_o), 32'(m_phase != 0));
            check("done", 32'(done_o), 32'(ed));
            check("result_valid", 32'(result_valid_o), 32'(m_rv | ed));
            check("winner", 32'(winner_o), ed ? 32'(exp_w) : 32'(m_win));
            check("winner_count", 32'(winner_count_o), ed ? 32'(exp_wc) : 32'(m_wc));
            check("tie", 32'(tie_o), ed ? 32'(exp_tie) : 32'(m_tie));
            check("total", 32'(total_o), ed ? 32'(exp_tot) : 32'(m_tot));
            if (m_phase <= N)
                check("rd_sel", 32'(rd_sel_o), (m_phase == 0) ? 32'd0 : 32'(m_phase - 1));
            if (done_o) n_done <= n_done + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_tally(input logic [CW-1:0] a, b, c, d);
        tally[0] = a;
        tally[1] = b;
        tally[2] = c;
        tally[3] = d;
    endtask

    // Leaves the caller at the falling edge of the done cycle.
    task automatic wait_done(input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done_o && k < 20);
        check({tag, " done_seen"}, 32'(done_o), 32'd1);
    endtask

    task automatic lit(input string tag, input int w, input int wc, input int t, input int tot);
        check({tag, " winner"}, 32'(winner_o), 32'(w));
        check({tag, " winner_count"}, 32'(winner_count_o), 32'(wc));
        check({tag, " tie"}, 32'(tie_o), 32'(t));
        check({tag, " total"}, 32'(total_o), 32'(tot));
        check({tag, " result_valid"}, 32'(result_valid_o), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        set_tally(0, 0, 0, 0);
        rst = 1'b1;
        tick(1);
        chk_en = 1'b1;
        tick(1);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset total", 32'(total_o), 32'd0);
        rst = 1'b0;
        tick(2);

        // Basic scan with literal rd_sel sequence.
        set_tally(5, 12, 3, 7);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check("t1 rd_sel", 32'(rd_sel_o), 32'(i));
        end
        wait_done("t1");
        lit("t1", 1, 12, 0, 27);
        tick(2);

        set_tally(9, 4, 9, 1);
        start = 1'b1; tick(1); start = 1'b0;
        wait_done("t2");
        lit("t2", 0, 9, 1, 23);
        tick(2);

        set_tally(0, 0, 0, 0);
        start = 1'b1; tick(1); start = 1'b0;
        wait_done("t3");
        lit("t3", 0, 0, 1, 0);
        tick(2);

        set_tally(CMAX, CMAX, CMAX, CMAX);
        start = 1'b1; tick(1); start = 1'b0;
        wait_done("t4");
        lit("t4", 0, 2097151, 1, 8388604);
        tick(2);

        // Starts during SCAN are ignored.
        set_tally(1, 2, 3, 4);
        d0 = n_done;
        start = 1'b1; tick(1);
        start = 1'b0; tick(1);
        start = 1'b1; tick(2);
        start = 1'b0;
        wait_done("t5");
        lit("t5", 3, 4, 0, 10);
        tick(4);
        check("t5 done_count", 32'(n_done - d0), 32'd1);
        check("t5 idle", 32'(busy_o), 32'd0);

        // Reset mid-scan discards the scan.
        set_tally(5, 12, 3, 7);
        start = 1'b1; tick(1);
        start = 1'b0; tick(2);
        rst = 1'b1; tick(1);
        rst = 1'b0;
        d0 = n_done;
        @(negedge clk);
        check("t6 busy", 32'(busy_o), 32'd0);
        check("t6 result_valid", 32'(result_valid_o), 32'd0);
        check("t6 winner", 32'(winner_o), 32'd0);
        check("t6 total", 32'(total_o), 32'd0);
        tick(6);
        check("t6 no_done", 32'(n_done - d0), 32'd0);
        start = 1'b1; tick(1); start = 1'b0;
        wait_done("t6b");
        lit("t6b", 1, 12, 0, 27);
        tick(2);

        // Start held high: one scan per N+2 cycles.
        set_tally(7, 7, 2, 8);
        d0 = n_done;
        start = 1'b1; tick(18);
        start = 1'b0; tick(8);
        check("t7 done_count", 32'(n_done - d0), 32'd3);

        // Randomised tallies, gaps, stray starts and occasional resets.
        for (int it = 0; it < 30; it++) begin
            int mode = $urandom_range(0, 2);
            for (int i = 0; i < N; i++) begin
                if (mode == 0) tally[i] = CW'($urandom_range(0, 3));
                else if (mode == 1) tally[i] = CW'($urandom);
                else tally[i] = CMAX - CW'($urandom_range(0, 2));
            end
            tick($urandom_range(0, 3));
            start = 1'b1; tick(1);
            if ($urandom_range(0, 5) == 0) begin
                start = 1'b0;
                tick($urandom_range(0, 3));
                rst = 1'b1; tick(1); rst = 1'b0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    start = 1'($urandom_range(0, 1));
                    tick(1);
                end
                start = 1'b0;
                @(negedge clk);
                check("rnd done", 32'(done_o), 32'd1);
            end
            tick(1);
        end

        tick(3);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
